// File: rtl/dm_trig_pkg.sv
// Shared constants and the state encoding for the channel trigger builder.
// Pure declarations, no latency.
// No flow control of its own.
package dm_trig_pkg;

    localparam int NUM_CH  = 128;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 8;
    localparam int FRAME_W = 16;
    localparam int DROP_W  = 16;

    typedef enum logic {
        ACCUM   = 1'b0,
        HOLDOFF = 1'b1
    } trig_state_e;

endpackage

// File: rtl/trig_align_delay.sv
// Fixed-depth shift register used to line {enable, rd_addr} up with the comparator decision.
// Latency: DEPTH cycles.
// No backpressure; shifts every cycle.
module trig_align_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift the presented word down the pipe; reset flushes it to idle (enable=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/channel_trigger_builder.sv
// Builds a per-frame channel hit map, applies multiplicity cut and hold-off, emits a trigger record.
// Latency: trig_valid rises one cycle after the aligned last-channel decision.
// Single-entry valid/ready buffer; a qualified frame arriving while it is full is counted in drop_cnt.
// Optional TRIG_TIMESTAMP_EN adds a 32-bit cycle timestamp to the record.
module channel_trigger_builder
    import dm_trig_pkg::*;
#(
    parameter int DECISION_LATENCY = 4,
    parameter int HOLDOFF_FRAMES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               decision,
    input  logic [CNT_W-1:0]   mult_thresh,
    input  logic               trig_ready,
    output logic               trig_valid,
    output logic [NUM_CH-1:0]  trig_hitmap,
    output logic [CNT_W-1:0]   trig_hitcount,
    output logic [FRAME_W-1:0] trig_frame_id,
    output logic [DROP_W-1:0]  drop_cnt
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [31:0]        trig_timestamp
`endif
);

    localparam int HO_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    logic [ADDR_W:0]      al_vec;
    logic                 al_en;
    logic [ADDR_W-1:0]    al_addr;
    logic [NUM_CH-1:0]    map_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 armed_q;
    logic [FRAME_W-1:0]   frame_cnt_q;
    trig_state_e          state_q, state_d;
    logic [HO_W-1:0]      holdoff_q, holdoff_d;
    logic                 hit_set;
    logic                 hit_new;
    logic [NUM_CH-1:0]    map_fin;
    logic [CNT_W-1:0]     cnt_fin;
    logic                 frame_end;
    logic                 frame_eval;
    logic                 buf_free;
    logic                 load_rec;
    logic                 drop_evt;

    trig_align_delay #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (DECISION_LATENCY)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({enable, rd_addr}),
        .dout  (al_vec)
    );

    assign al_en   = al_vec[ADDR_W];
    assign al_addr = al_vec[ADDR_W-1:0];

    // A repeated channel only ORs into the map; the count grows on 0->1 transitions only.
    assign hit_set    = al_en && decision;
    assign hit_new    = hit_set && !map_q[al_addr];
    assign map_fin    = map_q | ({{(NUM_CH-1){1'b0}}, hit_set} << al_addr);
    assign cnt_fin    = cnt_q + {{(CNT_W-1){1'b0}}, hit_new};
    assign frame_end  = al_en && (al_addr == ADDR_W'(NUM_CH - 1));
    assign frame_eval = frame_end && armed_q;
    assign buf_free   = !trig_valid || trig_ready;

    // Accumulate hits; the map clears on every last-channel cycle, armed or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= '0;
            cnt_q <= '0;
        end else if (frame_end) begin
            map_q <= '0;
            cnt_q <= '0;
        end else begin
            map_q <= map_fin;
            cnt_q <= cnt_fin;
        end
    end

    // Arm on the first aligned channel 0 so partial frames are never evaluated; count evaluated frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (al_en && (al_addr == '0)) armed_q <= 1'b1;
            if (frame_eval) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    // State and hold-off counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            holdoff_q <= '0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= holdoff_d;
        end
    end

    // Multiplicity cut, buffer-load / drop decision, and hold-off countdown over armed frame ends.
    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        load_rec  = 1'b0;
        drop_evt  = 1'b0;
        case (state_q)
            ACCUM: begin
                if (frame_eval && (cnt_fin >= mult_thresh)) begin
                    if (buf_free) begin
                        load_rec = 1'b1;
                        if (HOLDOFF_FRAMES != 0) begin
                            state_d   = HOLDOFF;
                            holdoff_d = HO_W'(HOLDOFF_FRAMES);
                        end
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (frame_eval) begin
                    holdoff_d = holdoff_q - 1'b1;
                    if (holdoff_q == HO_W'(1)) state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Single-entry record buffer; a same-cycle handshake frees the slot for a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_valid    <= 1'b0;
            trig_hitmap   <= '0;
            trig_hitcount <= '0;
            trig_frame_id <= '0;
        end else if (load_rec) begin
            trig_valid    <= 1'b1;
            trig_hitmap   <= map_fin;
            trig_hitcount <= cnt_fin;
            trig_frame_id <= frame_cnt_q + 1'b1;
        end else if (trig_valid && trig_ready) begin
            trig_valid    <= 1'b0;
        end
    end

    // Saturating count of qualified frames lost to a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle counter, sampled into the record on the load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q           <= '0;
            trig_timestamp <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (load_rec) trig_timestamp <= ts_q;
        end
    end
`else
    // Record carries no timestamp in this build.
`endif

endmodule

// File: tb/tb_channel_trigger_builder.sv
// Drives two builders (hold-off 2 and hold-off 0) with the same channel scan and
// compares every cycle against a frame-level reference model.
module tb_channel_trigger_builder;

    localparam int DL = 4;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [6:0]   rd_addr;
    logic         decision;
    logic [7:0]   mult_thresh;
    logic         rdy [2];
    logic         tv  [2];
    logic [127:0] hm  [2];
    logic [7:0]   hc  [2];
    logic [15:0]  fid [2];
    logic [15:0]  dc  [2];
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]  ts  [2];
`endif

    channel_trigger_builder #(.DECISION_LATENCY(DL), .HOLDOFF_FRAMES(2)) dut_h2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_addr(rd_addr), .decision(decision),
        .mult_thresh(mult_thresh), .trig_ready(rdy[0]), .trig_valid(tv[0]),
        .trig_hitmap(hm[0]), .trig_hitcount(hc[0]), .trig_frame_id(fid[0]), .drop_cnt(dc[0])
`ifdef TRIG_TIMESTAMP_EN
        , .trig_timestamp(ts[0])
`endif
    );

    channel_trigger_builder #(.DECISION_LATENCY(DL), .HOLDOFF_FRAMES(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_addr(rd_addr), .decision(decision),
        .mult_thresh(mult_thresh), .trig_ready(rdy[1]), .trig_valid(tv[1]),
        .trig_hitmap(hm[1]), .trig_hitcount(hc[1]), .trig_frame_id(fid[1]), .drop_cnt(dc[1])
`ifdef TRIG_TIMESTAMP_EN
        , .trig_timestamp(ts[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Presentation history: index 0 is this cycle, index DL is the one whose decision is due now.
    logic       h_en   [DL+1];
    logic [6:0] h_addr [DL+1];
    logic       h_d    [DL+1];

    logic rdy_base [2];
    logic rdy_end  [2];
    logic rand_rdy;

    // Reference model state, one copy per instance.
    int           hold_of [2] = '{2, 0};
    logic [127:0] m_map   [2];
    bit           m_armed [2];
    int           m_frame [2];
    int           m_hold  [2];
    bit           m_vld   [2];
    logic [127:0] m_hm    [2];
    int           m_hc    [2];
    int           m_fid   [2];
    int           m_drop  [2];
    logic [31:0]  tmask   [2];

    task automatic model_update();
        bit hs, full;
        int cnt;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_map[k] = '0; m_armed[k] = 0; m_frame[k] = 0; m_hold[k] = 0; m_vld[k] = 0;
                m_hm[k] = '0; m_hc[k] = 0; m_fid[k] = 0; m_drop[k] = 0;
            end else begin
                hs   = m_vld[k] && rdy[k];
                full = m_vld[k] && !hs;
                if (hs) m_vld[k] = 0;
                if (h_en[DL]) begin
                    if (h_d[DL]) m_map[k][h_addr[DL]] = 1'b1;
                    if (h_addr[DL] == 0) m_armed[k] = 1;
                    if (h_addr[DL] == 127) begin
                        if (m_armed[k]) begin
                            m_frame[k] = (m_frame[k] + 1) % 65536;
                            cnt = $countones(m_map[k]);
                            if (m_hold[k] > 0) begin
                                m_hold[k]--;
                            end else if (cnt >= int'(mult_thresh)) begin
                                if (!full) begin
                                    m_vld[k] = 1; m_hm[k] = m_map[k]; m_hc[k] = cnt;
                                    m_fid[k] = m_frame[k]; m_hold[k] = hold_of[k];
                                end else if (m_drop[k] < 65535) begin
                                    m_drop[k]++;
                                end
                            end
                        end
                        m_map[k] = '0;
                    end
                end
            end
        end
        if (!rst_n) begin
            for (int i = 0; i <= DL; i++) begin
                h_en[i] = 1'b0; h_addr[i] = '0; h_d[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("h%0d_valid", hold_of[k]),    tv[k],  m_vld[k]);
            chk($sformatf("h%0d_hitmap", hold_of[k]),   hm[k],  m_hm[k]);
            chk($sformatf("h%0d_hitcount", hold_of[k]), hc[k],  m_hc[k]);
            chk($sformatf("h%0d_frame_id", hold_of[k]), fid[k], m_fid[k]);
            chk($sformatf("h%0d_drop_cnt", hold_of[k]), dc[k],  m_drop[k]);
            if (tv[k] && fid[k] < 16'd32) tmask[k][fid[k][4:0]] = 1'b1;
        end
    endtask

    task automatic step(input logic en, input logic [6:0] addr, input logic d);
        for (int i = DL; i > 0; i--) begin
            h_en[i] = h_en[i-1]; h_addr[i] = h_addr[i-1]; h_d[i] = h_d[i-1];
        end
        h_en[0] = en; h_addr[0] = addr; h_d[0] = d;
        enable   = en;
        rd_addr  = addr;
        decision = h_d[DL];
        for (int k = 0; k < 2; k++)
            rdy[k] = (rand_rdy ? 1'($urandom_range(0, 1)) : rdy_base[k])
                     | (rdy_end[k] && h_en[DL] && (h_addr[DL] == 7'd127));
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'($urandom), 1'($urandom));
    endtask

    task automatic frame(input logic [127:0] hits, input int idle_pct, input int dup_ch,
                         input bit idle_dec1, input int rst_lo, input int rst_hi);
        for (int c = 0; c < 128; c++) begin
            rst_n = !(c >= rst_lo && c < rst_hi);
            while (int'($urandom_range(0, 99)) < idle_pct)
                step(1'b0, 7'($urandom), idle_dec1 ? 1'b1 : 1'($urandom));
            step(1'b1, 7'(c), hits[c]);
            if (c == dup_ch) step(1'b1, 7'(c), 1'b1);
        end
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
    endtask

    function automatic logic [127:0] n_hits(input int n);
        logic [127:0] h;
        h = '0;
        while ($countones(h) < n) h[$urandom_range(0, 127)] = 1'b1;
        return h;
    endfunction

    function automatic logic [127:0] density_hits(input int pct);
        logic [127:0] h;
        for (int c = 0; c < 128; c++) h[c] = (int'($urandom_range(0, 99)) < pct);
        return h;
    endfunction

    logic [127:0] hits;
    logic [127:0] exp_map;
    int           thr_pick;

    initial begin
        rst_n = 1'b0; enable = 1'b0; rd_addr = '0; decision = 1'b0; mult_thresh = '0;
        rand_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = 1'b0; rdy_base[k] = 1'b1; rdy_end[k] = 1'b0; tmask[k] = '0;
        end
        for (int i = 0; i <= DL; i++) begin
            h_en[i] = 1'b0; h_addr[i] = '0; h_d[i] = 1'b0;
        end
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", tv[k], 0);
            chk("reset_hitmap", hm[k], 0);
            chk("reset_frame_id", fid[k], 0);
            chk("reset_drop", dc[k], 0);
        end

        // Channels 3, 17, 127 hit; threshold met exactly.
        hits = '0; hits[3] = 1'b1; hits[17] = 1'b1; hits[127] = 1'b1;
        exp_map = hits;
        mult_thresh = 8'd3;
        frame(hits, 10, -1, 0, -1, -1);
        idle(DL + 2);
        for (int k = 0; k < 2; k++) begin
            chk("t1_hitmap", hm[k], exp_map);
            chk("t1_hitcount", hc[k], 3);
            chk("t1_frame_id", fid[k], 1);
        end

        // Threshold one above the count: no trigger, frame counter still advances.
        mult_thresh = 8'd4;
        frame(hits, 10, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t2_frame_id_held", fid[1], 1);
        chk("t2_drop", dc[1], 0);
        mult_thresh = 8'd0;
        frame(hits, 10, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t2_next_frame_id", fid[1], 3);

        // Hold-off pattern over seven frames of five hits each.
        do_reset();
        mult_thresh = 8'd1;
        for (int k = 0; k < 2; k++) tmask[k] = '0;
        for (int f = 0; f < 7; f++) frame(n_hits(5), 5, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t3_h2_trig_frames", tmask[0], 32'h92);
        chk("t3_h0_trig_frames", tmask[1], 32'hFE);

        // Buffer full: drops, then a same-cycle handshake at a frame end.
        do_reset();
        rdy_base[0] = 1'b0; rdy_base[1] = 1'b0;
        for (int f = 0; f < 3; f++) frame(n_hits(5), 5, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t4_h0_held_frame", fid[1], 1);
        chk("t4_h0_drops", dc[1], 2);
        chk("t4_h2_drops", dc[0], 0);
        rdy_end[0] = 1'b1; rdy_end[1] = 1'b1;
        frame(n_hits(5), 5, -1, 0, -1, -1);
        idle(DL + 2);
        rdy_end[0] = 1'b0; rdy_end[1] = 1'b0;
        chk("t4_h0_frame4", fid[1], 4);
        chk("t4_h0_drops_after", dc[1], 2);
        chk("t4_h0_valid", tv[1], 1);
        rdy_base[0] = 1'b1; rdy_base[1] = 1'b1;
        frame(n_hits(5), 5, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t4_h0_frame5", fid[1], 5);
        chk("t4_h0_drops_end", dc[1], 2);

        // Reset mid-scan: the partial frame must not trigger even with threshold 0.
        do_reset();
        mult_thresh = 8'd0;
        frame(density_hits(30), 5, -1, 0, 60, 90);
        hits = density_hits(10);
        frame(hits, 5, -1, 0, -1, -1);
        idle(DL + 2);
        chk("t5_first_frame_id", fid[1], 1);
        chk("t5_hitcount", hc[1], $countones(hits));

        // Duplicate channel and disabled cycles carrying decision=1.
        do_reset();
        hits = '0; hits[10] = 1'b1;
        exp_map = hits;
        frame(hits, 25, 10, 1, -1, -1);
        idle(DL + 2);
        chk("t6_hitcount", hc[1], 1);
        chk("t6_hitmap", hm[1], exp_map);

        // Random scans, thresholds and readout backpressure.
        do_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 14; f++) begin
            thr_pick = $urandom_range(0, 11);
            mult_thresh = (thr_pick < 9) ? 8'(thr_pick) : (thr_pick == 9 ? 8'd128 : 8'd200);
            frame(density_hits($urandom_range(0, 8)), 15,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 127)) : -1, 0, -1, -1);
        end
        idle(DL + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
